// File: rtl/stream_arbiter_qos_rr_if.sv
// Bundle of the N:1 arbiter's stream signals: per-stream source side plus
// the single shared sink side. The arbiter uses the master view; the
// environment driving sources and the sink uses the slave view.
interface stream_arbiter_qos_rr_if #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS_WIDTH  = 4,
  parameter int STREAM_COUNT = 4,
  parameter int T_ID_WIDTH   = $clog2(STREAM_COUNT)
);
  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_in;
  logic [STREAM_COUNT-1:0][T_QOS_WIDTH-1:0]  s_qos_in;
  logic [STREAM_COUNT-1:0]                   s_last_in;
  logic [STREAM_COUNT-1:0]                   s_valid_in;
  logic [STREAM_COUNT-1:0]                   s_ready_out;
  logic [T_DATA_WIDTH-1:0]                   m_data_out;
  logic [T_QOS_WIDTH-1:0]                    m_qos_out;
  logic [T_ID_WIDTH-1:0]                     m_id_out;
  logic                                      m_last_out;
  logic                                      m_valid_out;
  logic                                      m_ready_in;

  modport master (
    input  s_data_in, s_qos_in, s_last_in, s_valid_in, m_ready_in,
    output s_ready_out, m_data_out, m_qos_out, m_id_out, m_last_out, m_valid_out
  );

  modport slave (
    output s_data_in, s_qos_in, s_last_in, s_valid_in, m_ready_in,
    input  s_ready_out, m_data_out, m_qos_out, m_id_out, m_last_out, m_valid_out
  );
endinterface

// File: rtl/stream_arbiter_qos_rr.sv
// Packet-level N:1 stream arbiter. Highest effective QoS wins, ties are
// broken round-robin starting after the last winner, and streams that keep
// losing are promoted above every QoS level once their age saturates.
// A 2-entry registered skid buffer feeds the output so that input ready
// depends only on local registers, never on m_ready_in.
module stream_arbiter_qos_rr #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS_WIDTH  = 4,
  parameter int STREAM_COUNT = 4,
  parameter int T_ID_WIDTH   = $clog2(STREAM_COUNT),
  parameter int AGE_LIMIT    = 15
) (
  input logic clk,
  input logic rst_n,
  stream_arbiter_qos_rr_if.master bus
);
  localparam int AGE_WIDTH  = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;
  localparam int PRIO_WIDTH = T_QOS_WIDTH + 1;
  localparam logic [AGE_WIDTH-1:0]  AGE_MAX   = AGE_WIDTH'(AGE_LIMIT);
  localparam logic [PRIO_WIDTH-1:0] AGED_PRIO = PRIO_WIDTH'(1) << T_QOS_WIDTH;

  typedef enum logic {IDLE, ACTIVE} state_t;

  typedef struct packed {
    logic [T_DATA_WIDTH-1:0] data;
    logic                    last;
    logic [T_ID_WIDTH-1:0]   id;
    logic [T_QOS_WIDTH-1:0]  qos;
  } entry_t;

  state_t                 state_reg;
  logic [T_ID_WIDTH-1:0]  rr_ptr_reg;
  logic [T_ID_WIDTH-1:0]  grant_id_reg;
  logic [T_QOS_WIDTH-1:0] grant_qos_reg;
  entry_t                 head_reg;
  entry_t                 tail_reg;
  logic [1:0]             count_reg;

  logic [PRIO_WIDTH-1:0]   eff_prio [STREAM_COUNT];
  logic [PRIO_WIDTH-1:0]   max_prio;
  logic [STREAM_COUNT-1:0] candidate;
  logic [T_ID_WIDTH-1:0]   winner;
  logic                    any_valid;
  logic                    grant_event;
  logic                    room;
  logic                    accept;
  logic                    pop;
  entry_t                  in_entry;

  assign any_valid   = |bus.s_valid_in;
  assign grant_event = (state_reg == IDLE) && any_valid;
  assign room        = (state_reg == ACTIVE) && (count_reg != 2'd2);
  assign accept      = bus.s_valid_in[grant_id_reg] && bus.s_ready_out[grant_id_reg];
  assign pop         = (count_reg != 2'd0) && bus.m_ready_in;

  assign in_entry.data = bus.s_data_in[grant_id_reg];
  assign in_entry.last = bus.s_last_in[grant_id_reg];
  assign in_entry.id   = grant_id_reg;
  assign in_entry.qos  = grant_qos_reg;

  generate
    for (genvar gi = 0; gi < STREAM_COUNT; gi++) begin : g_stream
      logic [AGE_WIDTH-1:0] age_reg;

      assign eff_prio[gi] = (AGE_LIMIT != 0 && age_reg == AGE_MAX) ?
                            AGED_PRIO : {1'b0, bus.s_qos_in[gi]};
      assign candidate[gi] = bus.s_valid_in[gi] && (eff_prio[gi] == max_prio);
      assign bus.s_ready_out[gi] = room && (grant_id_reg == T_ID_WIDTH'(gi));

      // Age: losers that were contending count up (saturating), winner clears
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          age_reg <= '0;
        end else if (grant_event) begin
          if (winner == T_ID_WIDTH'(gi)) begin
            age_reg <= '0;
          end else if (bus.s_valid_in[gi] && age_reg != AGE_MAX) begin
            age_reg <= age_reg + AGE_WIDTH'(1);
          end
        end
      end
    end
  endgenerate

  // Highest effective priority among the streams currently requesting
  always_comb begin
    max_prio = '0;
    for (int i = 0; i < STREAM_COUNT; i++) begin
      if (bus.s_valid_in[i] && eff_prio[i] > max_prio) begin
        max_prio = eff_prio[i];
      end
    end
  end

  // Round-robin pick among top-priority candidates, starting after the last winner
  always_comb begin
    int   idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    winner = rr_ptr_reg;
    for (int k = 1; k <= STREAM_COUNT; k++) begin
      idx = (int'(rr_ptr_reg) + k) % STREAM_COUNT;
      if (!found && candidate[idx]) begin
        winner = T_ID_WIDTH'(idx);
        found  = 1'b1;
      end
    end
  end

  // Packet lock FSM: grant in IDLE, release on the granted stream's last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= T_ID_WIDTH'(STREAM_COUNT - 1);
      grant_id_reg  <= '0;
      grant_qos_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            state_reg     <= ACTIVE;
            rr_ptr_reg    <= winner;
            grant_id_reg  <= winner;
            grant_qos_reg <= bus.s_qos_in[winner];
          end
        end
        default: begin
          if (accept && in_entry.last) begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

  // Two-entry skid buffer; a push can never meet a full buffer since ready is withheld
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= 2'd0;
    end else begin
      case (count_reg)
        2'd0: begin
          if (accept) begin
            head_reg  <= in_entry;
            count_reg <= 2'd1;
          end
        end
        2'd1: begin
          if (accept && pop) begin
            head_reg <= in_entry;
          end else if (accept) begin
            tail_reg  <= in_entry;
            count_reg <= 2'd2;
          end else if (pop) begin
            count_reg <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_reg  <= tail_reg;
            count_reg <= 2'd1;
          end
        end
      endcase
    end
  end

  assign bus.m_data_out  = head_reg.data;
  assign bus.m_last_out  = head_reg.last;
  assign bus.m_id_out    = head_reg.id;
  assign bus.m_qos_out   = head_reg.qos;
  assign bus.m_valid_out = (count_reg != 2'd0);
endmodule

// File: tb/tb_stream_arbiter_qos_rr.sv
// Directed bench for the QoS round-robin arbiter. Per-stream source queues
// feed the inputs; expected output beats are queued in predicted grant order
// and popped as the sink accepts beats.
module tb_stream_arbiter_qos_rr;
  logic clk;
  logic rst_n;

  stream_arbiter_qos_rr_if #(.T_DATA_WIDTH(8), .T_QOS_WIDTH(4), .STREAM_COUNT(4)) bus ();

  stream_arbiter_qos_rr #(
    .T_DATA_WIDTH(8), .T_QOS_WIDTH(4), .STREAM_COUNT(4), .AGE_LIMIT(15)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [8:0]  src_q [4][$];   // {last, data}
  logic [14:0] exp_q [$];      // {id, qos, last, data}
  int          src_cnt [4];
  int          exp_cnt [4];
  logic [3:0]  qos_v [4];
  logic [3:0]  pause;
  logic        m_rdy;
  logic [3:0]  acc;
  logic        chk_lat;
  logic        lat_pending;
  logic [7:0]  lat_data;
  int          last_acc_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] mk_data(input int s, input int p, input int b);
    logic [1:0] s2;
    logic [2:0] p3;
    logic [2:0] b3;
    s2 = 2'(s);
    p3 = 3'(p);
    b3 = 3'(b);
    return {s2, p3, b3};
  endfunction

  task automatic src_pkt(input int s, input int n);
    for (int b = 0; b < n; b++) begin
      src_q[s].push_back({(b == n - 1), mk_data(s, src_cnt[s], b)});
    end
    src_cnt[s]++;
  endtask

  task automatic exp_pkt(input int s, input int n, input int q);
    logic [1:0] id2;
    logic [3:0] q4;
    id2 = 2'(s);
    q4  = 4'(q);
    for (int b = 0; b < n; b++) begin
      exp_q.push_back({id2, q4, (b == n - 1), mk_data(s, exp_cnt[s], b)});
    end
    exp_cnt[s]++;
  endtask

  function automatic logic src_busy();
    logic busy;
    busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() != 0) busy = 1'b1;
    end
    return busy;
  endfunction

  // One clock: retire accepted source beats, drive next inputs, observe handshakes
  task automatic tick();
    logic [14:0] obs;
    logic [14:0] expv;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) void'(src_q[i].pop_front());
    end
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() != 0 && !pause[i]) begin
        bus.s_valid_in[i] = 1'b1;
        bus.s_last_in[i]  = src_q[i][0][8];
        bus.s_data_in[i]  = src_q[i][0][7:0];
      end else begin
        bus.s_valid_in[i] = 1'b0;
        bus.s_last_in[i]  = 1'b0;
        bus.s_data_in[i]  = 8'h00;
      end
      bus.s_qos_in[i] = qos_v[i];
    end
    bus.m_ready_in = m_rdy;
    #1;
    if (chk_lat && lat_pending) begin
      check("latency_valid", bus.m_valid_out, 1);
      check("latency_data", bus.m_data_out, lat_data);
    end
    acc = bus.s_valid_in & bus.s_ready_out;
    lat_pending = |acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) lat_data = bus.s_data_in[i];
    end
    if (chk_lat && |acc) begin
      if (last_acc_cyc >= 0) check("bubble_gap", cyc - last_acc_cyc, 2);
      last_acc_cyc = cyc;
    end
    if (bus.m_valid_out && bus.m_ready_in) begin
      obs = {bus.m_id_out, bus.m_qos_out, bus.m_last_out, bus.m_data_out};
      check("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        expv = exp_q.pop_front();
        check("out_beat", obs, expv);
        $display("beat id=%0d qos=%0d last=%0b data=%02h", bus.m_id_out, bus.m_qos_out,
                 bus.m_last_out, bus.m_data_out);
      end
    end
  endtask

  task automatic run_until(input string tag, input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || src_busy()) && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, (exp_q.size() != 0 || src_busy()), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.s_data_in = '0;
    bus.s_qos_in = '0;
    bus.s_last_in = '0;
    bus.s_valid_in = '0;
    bus.m_ready_in = 1'b0;
    pause = '0;
    m_rdy = 1'b1;
    acc = '0;
    chk_lat = 1'b0;
    lat_pending = 1'b0;
    lat_data = '0;
    last_acc_cyc = -1;
    for (int i = 0; i < 4; i++) begin
      src_cnt[i] = 0;
      exp_cnt[i] = 0;
      qos_v[i] = 4'd0;
    end

    // Reset state
    tick();
    tick();
    check("rst_m_valid", bus.m_valid_out, 0);
    check("rst_m_data", bus.m_data_out, 0);
    check("rst_m_id", bus.m_id_out, 0);
    check("rst_m_qos", bus.m_qos_out, 0);
    check("rst_m_last", bus.m_last_out, 0);
    check("rst_s_ready", bus.s_ready_out, 0);
    rst_n = 1'b1;
    tick();
    check("idle_s_ready", bus.s_ready_out, 0);

    // Equal QoS, single-beat packets: pure round-robin from stream 0
    chk_lat = 1'b1;
    last_acc_cyc = -1;
    src_pkt(0, 1); src_pkt(1, 1); src_pkt(2, 1); src_pkt(3, 1); src_pkt(0, 1);
    exp_pkt(0, 1, 0); exp_pkt(1, 1, 0); exp_pkt(2, 1, 0); exp_pkt(3, 1, 0); exp_pkt(0, 1, 0);
    run_until("drain_rr", 60);
    chk_lat = 1'b0;
    lat_pending = 1'b0;

    // QoS 3/7/7: streams 1,2 alternate; stream 0 promoted after 15 losses
    qos_v[0] = 4'd3; qos_v[1] = 4'd7; qos_v[2] = 4'd7; qos_v[3] = 4'd0;
    src_pkt(0, 2);
    for (int p = 0; p < 9; p++) src_pkt(1, 2);
    for (int p = 0; p < 8; p++) src_pkt(2, 2);
    for (int g = 0; g < 15; g++) exp_pkt((g % 2 == 0) ? 1 : 2, 2, 7);
    exp_pkt(0, 2, 3);
    exp_pkt(1, 2, 7);
    exp_pkt(2, 2, 7);
    run_until("drain_aging", 300);

    // Lock: stream 3 raises QoS mid-packet of stream 2
    qos_v[2] = 4'd5; qos_v[3] = 4'd0;
    src_pkt(2, 4); src_pkt(3, 1);
    exp_pkt(2, 4, 5); exp_pkt(3, 1, 15);
    tick(); tick(); tick();
    qos_v[3] = 4'd15;
    tick();
    check("lock_s_ready3", bus.s_ready_out[3], 0);
    run_until("drain_lock", 60);

    // Backpressure: sink stalls 5 cycles mid-packet
    qos_v[1] = 4'd2;
    src_pkt(1, 6);
    exp_pkt(1, 6, 2);
    tick(); tick(); tick();
    m_rdy = 1'b0;
    tick();
    begin
      logic [7:0] held;
      held = bus.m_data_out;
      for (int k = 0; k < 4; k++) begin
        tick();
        check("stall_valid", bus.m_valid_out, 1);
        check("stall_data", bus.m_data_out, held);
      end
    end
    check("stall_s_ready", bus.s_ready_out, 0);
    m_rdy = 1'b1;
    run_until("drain_stall", 60);

    // Granted stream pauses; a later higher-QoS stream must stay blocked
    qos_v[0] = 4'd1; qos_v[2] = 4'd9;
    src_pkt(0, 4);
    exp_pkt(0, 4, 1); exp_pkt(2, 1, 9);
    tick(); tick();
    src_pkt(2, 1);
    pause[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("pause_s_ready2", bus.s_ready_out[2], 0);
      check("pause_s_ready0", bus.s_ready_out[0], 1);
    end
    pause[0] = 1'b0;
    run_until("drain_pause", 60);

    // Reset with one beat buffered mid-packet, then first grant restarts at stream 0
    qos_v[0] = 4'd4; qos_v[1] = 4'd4;
    m_rdy = 1'b0;
    src_pkt(0, 3);
    tick(); tick(); tick();
    check("pre_rst_valid", bus.m_valid_out, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.m_valid_out, 0);
    check("mid_rst_data", bus.m_data_out, 0);
    check("mid_rst_id", bus.m_id_out, 0);
    check("mid_rst_qos", bus.m_qos_out, 0);
    check("mid_rst_last", bus.m_last_out, 0);
    check("mid_rst_s_ready", bus.s_ready_out, 0);
    for (int i = 0; i < 4; i++) begin
      src_q[i].delete();
      exp_cnt[i] = src_cnt[i];
    end
    exp_q.delete();
    acc = '0;
    lat_pending = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    m_rdy = 1'b1;
    src_pkt(1, 1); src_pkt(0, 1);
    exp_pkt(0, 1, 4); exp_pkt(1, 1, 4);
    run_until("drain_post_rst", 40);
    tick();
    check("final_idle_valid", bus.m_valid_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stream_arbiter_qos_rr.md
Name: stream_arbiter_qos_rr

Overview:
- Packet-level N:1 AXI-Stream-style arbiter with QoS priority and true round-robin among equal-priority contenders.
- Per-stream aging prevents low-QoS starvation.
- A registered 2-entry output skid buffer breaks the m_ready_in → s_ready_out combinational path.
- Sits between multiple packet sources and a single shared downstream sink.

Parameters:
- T_DATA_WIDTH, 8, data beat width.
- T_QOS_WIDTH, 4, QoS field width; larger value = higher priority; 0 = lowest (not special).
- STREAM_COUNT, 4, number of input streams, ≥2.
- T_ID_WIDTH, $clog2(STREAM_COUNT), width of m_id_out.
- AGE_LIMIT, 15, arbitration losses before a stream is promoted; 0 disables aging.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- s_data_in  in  [T_DATA_WIDTH] x STREAM_COUNT  per-stream data
- s_qos_in  in  [T_QOS_WIDTH] x STREAM_COUNT  per-stream QoS, sampled at grant
- s_last_in  in  STREAM_COUNT  per-stream end-of-packet
- s_valid_in  in  STREAM_COUNT  per-stream valid
- s_ready_out  out  STREAM_COUNT  per-stream ready
- m_data_out  out  T_DATA_WIDTH  output data
- m_qos_out  out  T_QOS_WIDTH  QoS latched at grant
- m_id_out  out  T_ID_WIDTH  granted stream index
- m_last_out  out  1  end-of-packet
- m_valid_out  out  1  output valid
- m_ready_in  in  1  downstream ready

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; rr_ptr=STREAM_COUNT-1 (first scan starts at stream 0); all age counters=0; skid buffer empty.
  - All m_* outputs=0, s_ready_out=0.
  - Reset mid-packet discards buffered beats and the grant; no partial-packet completion.
- States:
  - IDLE: if any s_valid_in, register the grant and go to ACTIVE next cycle. Grant decision is combinational on the current inputs.
  - ACTIVE: held until the granted stream's last beat is accepted (s_valid & s_ready & s_last of the granted stream), then back to IDLE. One input-side bubble cycle per packet.
- Selection (IDLE only):
  - Effective priority = 2^T_QOS_WIDTH if aged (age==AGE_LIMIT, AGE_LIMIT≠0), else s_qos_in.
  - Candidates = valid streams whose effective priority equals the maximum.
  - Winner = first candidate scanning rr_ptr+1, rr_ptr+2, … modulo STREAM_COUNT.
  - At grant: rr_ptr ← winner; granted_qos ← s_qos_in[winner]; granted_id ← winner.
- Aging:
  - At each grant event, every valid non-winning stream increments its age counter, saturating at AGE_LIMIT.
  - Winner's counter clears; non-valid streams keep their value.
  - Counter width $clog2(AGE_LIMIT+1), minimum 1.
- Lock:
  - Grant holds for the whole packet, regardless of QoS changes or higher-QoS arrivals.
  - A granted stream dropping valid mid-packet keeps the grant (wait).
  - Non-granted inputs are ignored, and their s_ready_out=0.
- Ready: s_ready_out[g] = (state==ACTIVE) & (buffer count<2), derived from registers only. No combinational path from m_ready_in.
- Skid buffer:
  - 2 entries of {data, last, id, qos}.
  - Push on accepted input beat, pop on m_valid_out & m_ready_in. Simultaneous push/pop keeps the count.
  - m_valid_out = count≠0; outputs driven from the head entry and registered.
  - Latency: beat accepted at cycle N is on m_* at N+1.
  - Full throughput of 1 beat/cycle within a packet when m_ready_in stays high.
- Output stability: while m_valid_out & !m_ready_in, all m_* remain stable.
- m_qos_out/m_id_out are constant across all beats of a packet.
- Single-beat packets (last on first beat) are legal: ACTIVE for one accepted beat, then IDLE.

Test Plan:
- Streams 0,1,2 valid, qos 3,7,7, 2-beat packets each, m_ready_in=1 → grant order 1,2,1,2…; stream 0 starts after 15 lost arbitrations via aging, m_qos_out=3 on its packet.
- All 4 streams valid qos=0, single-beat packets → m_id_out sequence 0,1,2,3,0; one bubble between packets on the input side; data appears 1 cycle after acceptance.
- Stream 2 granted with a 4-beat packet, stream 3 raises qos=15 mid-packet → all 4 beats of stream 2 complete before stream 3 wins; m_id_out=2 constant during the packet.
- m_ready_in low for 5 cycles mid-packet → buffer fills with 2 beats, s_ready_out drops; m_data_out stable; on release no beat is lost or duplicated.
- Granted stream deasserts s_valid_in for 3 cycles mid-packet → arbiter holds the grant and other valid streams stay blocked.
- rst_n asserted with 1 beat buffered mid-packet → next edge state outputs all 0, m_valid_out=0; after release, first grant is scanned from stream 0.
